// File: rtl/stage_ex_md.sv
// Execute stage: operand forwarding, base ALU and an iterative RV32M/RV64M multiply/divide unit.
// Optional macro MUL_FAST_EN: single-cycle registered multiplier for MUL/MULH/MULHSU/MULHU.
module stage_ex_md #(
  parameter int REG_WIDTH = 32,
  localparam int CNT_W = $clog2(REG_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [1:0]           forwardA,
  input  logic [1:0]           forwardB,
  input  logic [REG_WIDTH-1:0] ID_EX_data_out_1,
  input  logic [REG_WIDTH-1:0] ID_EX_data_out_2,
  input  logic [REG_WIDTH-1:0] ID_EX_imm_out,
  input  logic [REG_WIDTH-1:0] WB_data,
  input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
  input  logic [2:0]           ID_EX_alu_sel,
  input  logic                 ID_EX_BSel,
  input  logic                 ID_EX_md_en,
  input  logic [2:0]           ID_EX_md_op,
  output logic [REG_WIDTH-1:0] alu_out,
  output logic [REG_WIDTH-1:0] dataB,
  output logic                 md_stall,
  output logic                 md_done
);
  localparam int W = REG_WIDTH;
  localparam int SH_W = $clog2(REG_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0] acc;
  logic [W-1:0] b_reg;
  logic [2:0] op_reg;
  logic neg_reg;

  logic [W-1:0] data_a, alu_b, alu_res, md_result;
  logic [SH_W-1:0] shamt;

  always_comb begin
    unique case (forwardA)
      2'b00:   data_a = ID_EX_data_out_1;
      2'b01:   data_a = WB_data;
      2'b10:   data_a = EX_MEM_alu_out;
      default: data_a = '0;
    endcase
    unique case (forwardB)
      2'b00:   dataB = ID_EX_data_out_2;
      2'b01:   dataB = WB_data;
      2'b10:   dataB = EX_MEM_alu_out;
      default: dataB = '0;
    endcase
  end

  assign alu_b = ID_EX_BSel ? ID_EX_imm_out : dataB;
  assign shamt = alu_b[SH_W-1:0];

  always_comb begin
    unique case (ID_EX_alu_sel)
      3'd0:    alu_res = data_a + alu_b;
      3'd1:    alu_res = data_a - alu_b;
      3'd2:    alu_res = data_a & alu_b;
      3'd3:    alu_res = data_a | alu_b;
      3'd4:    alu_res = data_a ^ alu_b;
      3'd5:    alu_res = data_a << shamt;
      3'd6:    alu_res = data_a >> shamt;
      default: alu_res = W'($signed(data_a) >>> shamt);
    endcase
  end

  // Operand preparation: magnitudes, result sign and the special cases that skip iteration.
  logic signed_a, signed_b, sign_a, sign_b, is_div, div_zero, div_ovf, fast_path, neg_start;
  logic [W-1:0] a_mag, b_mag;
  logic [2*W-1:0] fast_acc;
  logic fast_neg;

  always_comb begin
    is_div    = ID_EX_md_op[2];
    signed_a  = (ID_EX_md_op == 3'd1) || (ID_EX_md_op == 3'd2) ||
                (ID_EX_md_op == 3'd4) || (ID_EX_md_op == 3'd6);
    signed_b  = (ID_EX_md_op == 3'd1) || (ID_EX_md_op == 3'd4) || (ID_EX_md_op == 3'd6);
    sign_a    = signed_a & data_a[W-1];
    sign_b    = signed_b & dataB[W-1];
    a_mag     = sign_a ? -data_a : data_a;
    b_mag     = sign_b ? -dataB : dataB;
    unique case (ID_EX_md_op)
      3'd1, 3'd4: neg_start = sign_a ^ sign_b;
      3'd2, 3'd6: neg_start = sign_a;
      default:    neg_start = 1'b0;
    endcase
    div_zero  = is_div && (dataB == '0);
    div_ovf   = ((ID_EX_md_op == 3'd4) || (ID_EX_md_op == 3'd6)) &&
                (data_a == {1'b1, {(W-1){1'b0}}}) && (dataB == {W{1'b1}});
    fast_path = div_zero || div_ovf;
    fast_neg  = 1'b0;
    fast_acc  = '0;
    if (div_zero) begin
      fast_acc = {data_a, {W{1'b1}}};
    end else if (div_ovf) begin
      fast_acc = {{W{1'b0}}, data_a};
    end
`ifdef MUL_FAST_EN
    if (!is_div) begin
      fast_path = 1'b1;
      fast_acc  = a_mag * b_mag;
      fast_neg  = neg_start;
    end
`endif
  end

  always_comb begin
    state_next = state;
    md_stall   = 1'b0;
    md_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ID_EX_md_en) begin
          md_stall   = 1'b1;
          state_next = fast_path ? DONE : BUSY;
        end
      end
      BUSY: begin
        md_stall = 1'b1;
        if (cnt == CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        md_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      md_stall   = 1'b0;
      md_done    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  logic [W:0] mul_sum, div_trial, div_diff;
  logic [2*W-1:0] step_acc;

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_reg} : '0);
    div_trial = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_trial - {1'b0, b_reg};
    if (op_reg[2]) begin
      if (div_trial >= {1'b0, b_reg}) step_acc = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      else                            step_acc = {div_trial[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      step_acc = {mul_sum, acc[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      neg_reg <= 1'b0;
    end else if (!flush) begin
      if (state == IDLE && ID_EX_md_en) begin
        op_reg  <= ID_EX_md_op;
        b_reg   <= b_mag;
        cnt     <= CNT_W'(REG_WIDTH);
        acc     <= fast_path ? fast_acc : {{W{1'b0}}, a_mag};
        neg_reg <= fast_path ? fast_neg : neg_start;
      end else if (state == BUSY) begin
        acc <= step_acc;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  logic [2*W-1:0] prod;
  logic [W-1:0] q_val, r_val;

  always_comb begin
    prod  = neg_reg ? -acc : acc;
    q_val = neg_reg ? -acc[W-1:0] : acc[W-1:0];
    r_val = neg_reg ? -acc[2*W-1:W] : acc[2*W-1:W];
    unique case (op_reg)
      3'd0:             md_result = prod[W-1:0];
      3'd1, 3'd2, 3'd3: md_result = prod[2*W-1:W];
      3'd4, 3'd5:       md_result = q_val;
      default:          md_result = r_val;
    endcase
  end

  assign alu_out = (state == DONE) ? md_result : alu_res;

endmodule

// File: tb/tb_stage_ex_md.sv
// Directed self-checking bench for stage_ex_md; honours MUL_FAST_EN for multiply latency.
module tb_stage_ex_md;
  localparam int W = 32;
`ifdef MUL_FAST_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif

  logic clk = 1'b0;
  logic reset, flush;
  logic [1:0] forwardA, forwardB;
  logic [W-1:0] ID_EX_data_out_1, ID_EX_data_out_2, ID_EX_imm_out, WB_data, EX_MEM_alu_out;
  logic [2:0] ID_EX_alu_sel, ID_EX_md_op;
  logic ID_EX_BSel, ID_EX_md_en;
  logic [W-1:0] alu_out, dataB;
  logic md_stall, md_done;

  int errorCount = 0;
  int checkCount = 0;

  stage_ex_md #(.REG_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .forwardA(forwardA), .forwardB(forwardB),
    .ID_EX_data_out_1(ID_EX_data_out_1), .ID_EX_data_out_2(ID_EX_data_out_2),
    .ID_EX_imm_out(ID_EX_imm_out), .WB_data(WB_data), .EX_MEM_alu_out(EX_MEM_alu_out),
    .ID_EX_alu_sel(ID_EX_alu_sel), .ID_EX_BSel(ID_EX_BSel),
    .ID_EX_md_en(ID_EX_md_en), .ID_EX_md_op(ID_EX_md_op),
    .alu_out(alu_out), .dataB(dataB), .md_stall(md_stall), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] fa, input logic [1:0] fb,
                               input logic [W-1:0] rs1, input logic [W-1:0] rs2);
    forwardA         = fa;
    forwardB         = fb;
    ID_EX_data_out_1 = rs1;
    ID_EX_data_out_2 = rs2;
  endtask

  // Presents an M op in the cycle after the next edge, scrambles the operand buses while it runs,
  // then checks stall length, DONE-cycle outputs and the result.
  task automatic runMdOp(input string tag, input logic [2:0] op, input logic [1:0] fa,
                         input logic [1:0] fb, input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                         input logic [W-1:0] expected, input int expStall);
    int stalls;
    bit done;
    @(posedge clk); #1;
    applyStimulus(fa, fb, rs1, rs2);
    ID_EX_BSel    = 1'b1;
    ID_EX_imm_out = 32'h5A5A_0003;
    ID_EX_md_op   = op;
    ID_EX_md_en   = 1'b1;
    #1;
    checkOutput({tag, " stall0"}, W'(md_stall), 1);
    stalls = 1;
    done   = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
      WB_data        = $urandom;
      EX_MEM_alu_out = $urandom;
      #1;
      if (md_done) done = 1'b1;
      else if (md_stall) stalls++;
    end
    checkOutput({tag, " done"}, W'(done), 1);
    checkOutput({tag, " stall_in_done"}, W'(md_stall), 0);
    checkOutput({tag, " stall_len"}, W'(stalls), W'(expStall));
    checkOutput({tag, " result"}, alu_out, expected);
    ID_EX_md_en = 1'b0;
  endtask

  initial begin
    bit sawDone;
    reset = 1'b1; flush = 1'b0;
    applyStimulus(2'b00, 2'b00, 32'd0, 32'd0);
    ID_EX_imm_out = '0; WB_data = '0; EX_MEM_alu_out = '0;
    ID_EX_alu_sel = 3'd0; ID_EX_md_op = 3'd0; ID_EX_BSel = 1'b0; ID_EX_md_en = 1'b0;
    #12;
    checkOutput("reset md_stall", W'(md_stall), 0);
    checkOutput("reset md_done", W'(md_done), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus(2'b00, 2'b00, 32'd10, 32'd99);
    ID_EX_BSel = 1'b1; ID_EX_imm_out = 32'd5;
    #1;
    checkOutput("alu add imm", alu_out, 32'd15);
    checkOutput("alu stall", W'(md_stall), 0);
    applyStimulus(2'b01, 2'b10, 32'd1, 32'd2);
    WB_data = 32'h100; EX_MEM_alu_out = 32'h20; ID_EX_BSel = 1'b0;
    #1;
    checkOutput("alu fwd add", alu_out, 32'h120);
    checkOutput("dataB fwd exmem", dataB, 32'h20);
    applyStimulus(2'b11, 2'b11, 32'd1, 32'd2);
    ID_EX_BSel = 1'b1; ID_EX_imm_out = 32'h77;
    #1;
    checkOutput("alu zero A", alu_out, 32'h77);
    checkOutput("dataB zero", dataB, 32'h0);

    EX_MEM_alu_out = 32'd7; WB_data = 32'd6;
    runMdOp("MUL fwd", 3'd0, 2'b10, 2'b01, 32'hDEAD, 32'hBEEF, 32'd42, MUL_STALL);
    runMdOp("MULH", 3'd1, 2'b00, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_STALL);
    runMdOp("MULHSU", 3'd2, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALL);
    runMdOp("MULHU", 3'd3, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALL);
    runMdOp("MUL neg", 3'd0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, MUL_STALL);
    runMdOp("DIV", 3'd4, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    runMdOp("REM", 3'd6, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    runMdOp("DIVU", 3'd5, 2'b00, 2'b00, 32'd100, 32'd7, 32'd14, 33);
    runMdOp("REMU", 3'd7, 2'b00, 2'b00, 32'd100, 32'd7, 32'd2, 33);
    runMdOp("DIV by0", 3'd4, 2'b00, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runMdOp("REM by0", 3'd6, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
    runMdOp("REMU by0", 3'd7, 2'b00, 2'b00, 32'd5, 32'd0, 32'd5, 1);
    runMdOp("DIV ovf", 3'd4, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runMdOp("REM ovf", 3'd6, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    @(posedge clk); #2;
    checkOutput("idle after done", W'(md_done), 0);

    // Flush mid-divide: no result may ever appear.
    #1;
    applyStimulus(2'b00, 2'b00, 32'd100, 32'd7);
    ID_EX_md_op = 3'd5; ID_EX_md_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; ID_EX_md_en = 1'b0;
    #1;
    checkOutput("flush forces stall 0", W'(md_stall), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checkOutput("after flush stall", W'(md_stall), 0);
    sawDone = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (md_done) sawDone = 1'b1;
    end
    checkOutput("flush no done", W'(sawDone), 0);
    runMdOp("DIVU after flush", 3'd5, 2'b00, 2'b00, 32'd100, 32'd7, 32'd14, 33);

    // Reset mid-multiply discards the partial result.
    @(posedge clk); #1;
    applyStimulus(2'b00, 2'b00, 32'd1000, 32'd1000);
    ID_EX_md_op = 3'd0; ID_EX_md_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1; ID_EX_md_en = 1'b0;
    applyStimulus(2'b00, 2'b00, 32'd4, 32'd3);
    ID_EX_BSel = 1'b0; ID_EX_alu_sel = 3'd0;
    #1;
    checkOutput("midreset stall", W'(md_stall), 0);
    checkOutput("midreset alu", alu_out, 32'd7);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("after reset done", W'(md_done), 0);
    runMdOp("MUL after reset", 3'd0, 2'b00, 2'b00, 32'd3, 32'd3, 32'd9, MUL_STALL);

    @(posedge clk); #2;
    checkOutput("final idle done", W'(md_done), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/stage_ex_md.md
Name: stage_EX_md

Overview:
Next-generation execute stage. It keeps the 3-source operand forwarding, the immediate B-select and the combinational ALU path, and adds an iterative RV32M/RV64M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). Multi-cycle ops stall the pipeline through md_stall and present their result on alu_out in the release cycle. The block sits between the ID/EX and EX/MEM registers and replaces the plain EX stage.

Parameters:
REG_WIDTH, 32, datapath width; must be even and >= 8
CNT_W, $clog2(REG_WIDTH)+1, width of the iteration counter (derived; do not override)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-high
flush  input  1  synchronous abort of any M op in flight
forwardA  input  2  rs1 source select: 00 ID/EX, 01 WB_data, 10 EX_MEM_alu_out, 11 zero
forwardB  input  2  rs2 source select, same encoding as forwardA
ID_EX_data_out_1  input  REG_WIDTH  rs1 data
ID_EX_data_out_2  input  REG_WIDTH  rs2 data
ID_EX_imm_out  input  REG_WIDTH  immediate
WB_data  input  REG_WIDTH  WB forward value
EX_MEM_alu_out  input  REG_WIDTH  EX/MEM forward value
ID_EX_alu_sel  input  3  base ALU op (existing alu encoding)
ID_EX_BSel  input  1  ALU B = immediate when 1
ID_EX_md_en  input  1  current ID/EX instruction is an M-extension op
ID_EX_md_op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
alu_out  output  REG_WIDTH  EX result: ALU result, or M result in the DONE cycle
dataB  output  REG_WIDTH  forwarded rs2 (store data)
md_stall  output  1  freeze PC/IF/ID/ID-EX; insert bubble into EX/MEM
md_done  output  1  one-cycle pulse: M result valid on alu_out

Behaviour:
- Forwarding (dataA/dataB) and the ALU stay combinational, identical to the current stage; code 11 selects zero.
- FSM states: IDLE, BUSY, DONE. Reset: state IDLE, counter 0, operand/accumulator registers 0, md_done 0. md_stall is combinational and therefore 0 in reset.
- IDLE and ID_EX_md_en=1: md_stall=1 combinationally in that cycle. At the clock edge, latch the forwarded dataA/dataB (never the immediate), their signs and the op. Then go to BUSY with counter = REG_WIDTH. Fast-path ops go directly to DONE instead.
- Fast path (1 stall cycle):
  - DIV/DIVU by zero: quotient = all ones; REM/REMU by zero: remainder = dividend.
  - DIV/REM with dividend = -2^(W-1) and divisor = -1: quotient = dividend, remainder = 0.
- BUSY: one radix-2 step per cycle; counter decrements; md_stall=1. Leave BUSY when the counter reaches 1, entering DONE.
  - Multiply: shift-add on magnitudes into a 2W accumulator. MULH negates the product if signs differ. MULHSU treats B as unsigned. MUL returns the low W bits; MULH* return the high W bits.
  - Divide: restoring divide on magnitudes. Signed quotient is negated if signs differ; signed remainder takes the sign of the dividend.
- DONE: md_stall=0, md_done=1, alu_out = M result. Next edge returns to IDLE; the pipeline advances on that same edge.
- Latency (normal): op presented in cycle 0; md_stall high in cycles 0..W; result in cycle W+1. Stall length = W+1 cycles.
- Back-to-back M ops: the IDLE after DONE sees the new op and starts it; there is no extra bubble beyond the FSM itself.
- md_en=0: alu_out = ALU result, md_stall=0, FSM idle.
- Operand changes on the forward buses during BUSY are ignored (operands are latched).
- flush: in any state, go to IDLE next edge with md_done=0. md_stall is forced 0 while flush=1.
- reset asserted mid-operation: immediate return to IDLE; the partial result is discarded.

Optional Feature:
MUL_FAST_EN
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle full-width multiplier whose product is registered. Path is IDLE -> DONE with 1 stall cycle and result in cycle 1. Divide is unchanged.
- Undefined: all multiply ops use the iterative path (W+1 stall cycles). No multiplier array is inferred.

Test Plan:
- W=32, forwardA=10 (EX_MEM_alu_out=7), forwardB=01 (WB_data=6), MUL -> md_stall high 33 cycles, then alu_out=42 with md_done=1 for 1 cycle.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF after 1 stall cycle; REM 0x80000000 / 0xFFFFFFFF -> 0 after 1 stall cycle.
- DIVU in progress: flush at cycle 10 -> md_stall 0 next cycle, no md_done. Separate run: reset pulse at cycle 5 -> IDLE, then a fresh MUL 3 x 3 -> 9.
- md_en=0, ID_EX_BSel=1, imm=5, rs1=10, ALU add -> alu_out=15 same cycle, md_stall=0. With MUL_FAST_EN defined: MUL 7 x 6 -> 42 after 1 stall cycle.
